// File: rtl/instr_fetch_issue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_issue : instruction prefetch FIFO feeding the decoder one
//                     instruction at a time, stopping at a halt word.
// Revision: 1.0
// ---------------------------------------------------------------------------
module instr_fetch_issue #(
  parameter int                ADDR_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [31:0]       HALT_WORD  = 32'h00000073
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          imem_en,
  output logic [ADDR_W-1:0]             imem_addr,
  input  logic [31:0]                   imem_rdata,
  output logic [31:0]                   instruction,
  output logic                          rdy_bsy,
  input  logic                          dec_done,
  output logic [ADDR_W-1:0]             pc_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          halted
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  localparam logic [0:0] I_IDLE = 1'b0;
  localparam logic [0:0] I_WAIT = 1'b1;

  logic [1:0]        fstate_q, fstate_d;
  logic [0:0]        istate_q;
  logic [ADDR_W-1:0] pc_q;
  logic              pending_q;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [31:0]       instr_q;
  logic              rdy_q;

  logic [CNT_W:0]    w_occ;
  logic              w_room, w_ret, w_halt, w_push, w_req, w_pop;

  // Outstanding read counts against capacity so a push can never hit a full FIFO.
  assign w_occ  = {1'b0, count_q} + (CNT_W+1)'(pending_q);
  assign w_room = w_occ < (CNT_W+1)'(FIFO_DEPTH);
  assign w_ret  = pending_q && (fstate_q == S_RUN);
  assign w_halt = w_ret && (imem_rdata == HALT_WORD);
  assign w_push = w_ret && !w_halt;
  assign w_req  = (fstate_q == S_RUN) && !w_halt && w_room;
  assign w_pop  = (istate_q == I_IDLE) && (count_q != '0);

  always_comb begin
    fstate_d = fstate_q;
    case (fstate_q)
      S_IDLE:  if (start) fstate_d = S_RUN;
      S_RUN:   if (w_halt) fstate_d = S_STOP;
      default: fstate_d = fstate_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fstate_q  <= S_IDLE;
      istate_q  <= I_IDLE;
      pc_q      <= RESET_PC;
      pending_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      instr_q   <= '0;
      rdy_q     <= 1'b0;
    end else begin
      fstate_q  <= fstate_d;
      pending_q <= w_req;
      if (w_req) pc_q <= pc_q + 1'b1;
      if (w_push) wptr_q <= wptr_q + 1'b1;
      if (w_pop) rptr_q <= rptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      rdy_q <= w_pop;
      if (w_pop) begin
        instr_q  <= fifo_q[rptr_q];
        istate_q <= I_WAIT;
      end else if ((istate_q == I_WAIT) && dec_done) begin
        istate_q <= I_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) fifo_q[wptr_q] <= imem_rdata;
  end

  assign imem_en     = w_req;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign fifo_count  = count_q;
  assign instruction = instr_q;
  assign rdy_bsy     = rdy_q;
  assign halted      = (fstate_q == S_STOP) && (count_q == '0) && (istate_q == I_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_issue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_fetch_issue : scoreboard bench for instr_fetch_issue.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_instr_fetch_issue;
  localparam logic [31:0] HALT = 32'h00000073;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, dec_done;
  logic        imem_en, rdy_bsy, halted;
  logic [7:0]  imem_addr, pc_out;
  logic [31:0] imem_rdata, instruction;
  logic [2:0]  fifo_count;

  logic        start_w, dec_done_w;
  logic        imem_en_w, rdy_bsy_w, halted_w;
  logic [2:0]  imem_addr_w, pc_out_w, fifo_count_w;
  logic [31:0] imem_rdata_w, instruction_w;

  instr_fetch_issue u_dut (
    .clk(clk), .rst(rst), .start(start), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instruction(instruction), .rdy_bsy(rdy_bsy),
    .dec_done(dec_done), .pc_out(pc_out), .fifo_count(fifo_count), .halted(halted)
  );

  instr_fetch_issue #(.ADDR_W(3), .FIFO_DEPTH(4), .RESET_PC(3'd6)) u_dut_w (
    .clk(clk), .rst(rst), .start(start_w), .imem_en(imem_en_w), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata_w), .instruction(instruction_w), .rdy_bsy(rdy_bsy_w),
    .dec_done(dec_done_w), .pc_out(pc_out_w), .fifo_count(fifo_count_w), .halted(halted_w)
  );

  logic [31:0] imem   [256];
  logic [31:0] imem_w [8];
  always @(posedge clk) if (imem_en)   imem_rdata   <= imem[imem_addr];
  always @(posedge clk) if (imem_en_w) imem_rdata_w <= imem_w[imem_addr_w];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] exp_w_q[$];
  logic [2:0]  exp_addr_w_q[$];
  logic [7:0]  exp_addr  = '0;
  int          fetch_cnt = 0;
  int          pp_seen   = 0;

  // Decoder model control
  bit dec_auto  = 1'b1;
  int dec_delay = 2;
  bit owed      = 1'b0;
  bit spur      = 1'b0;

  // Monitor state: independent occupancy model built from observed requests/issues
  int          mcount   = 0;
  bit          push_p1  = 1'b0;
  bit          en_p     = 1'b0;
  bit          stopped  = 1'b0;
  bit          busy     = 1'b0;
  bit          prev_rdy = 1'b0;
  logic [31:0] held     = '0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        mcount = 0; push_p1 = 0; en_p = 0; stopped = 0; busy = 0; prev_rdy = 0;
      end else begin
        if (push_p1 && rdy_bsy && mcount == 2) pp_seen++;
        mcount = mcount + int'(push_p1) - int'(rdy_bsy);
        check("fifo_count", 32'(fifo_count), mcount);
        if (rdy_bsy) begin
          check("rdy_pulse", 32'(prev_rdy), 32'd0);
          if (exp_q.size() == 0) check("extra_issue", 32'(exp_q.size()), 32'd1);
          else begin
            held = exp_q.pop_front();
            check("issue", instruction, held);
            busy = 1'b1;
          end
        end else if (busy) begin
          check("hold", instruction, held);
          if (dec_done) busy = 1'b0;
        end
        if (imem_en) begin
          check("fetch_addr", 32'(imem_addr), 32'(exp_addr));
          exp_addr++;
          fetch_cnt++;
        end
        push_p1 = en_p && !stopped && (imem_rdata != HALT);
        if (en_p && imem_rdata == HALT) stopped = 1'b1;
        en_p     = imem_en;
        prev_rdy = rdy_bsy;
      end
    end
  end

  initial begin
    dec_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst) owed = 1'b0;
      else begin
        if (rdy_bsy) owed = 1'b1;
        if (spur) begin
          @(negedge clk) dec_done = 1'b1;
          @(negedge clk) dec_done = 1'b0;
          spur = 1'b0;
        end else if (owed && dec_auto) begin
          repeat (dec_delay) @(posedge clk);
          @(negedge clk) dec_done = 1'b1;
          @(negedge clk) dec_done = 1'b0;
          owed = 1'b0;
        end
      end
    end
  end

  initial begin
    dec_done_w = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        if (rdy_bsy_w) begin
          if (exp_w_q.size() == 0) check("w_extra_issue", 32'(exp_w_q.size()), 32'd1);
          else check("w_issue", instruction_w, exp_w_q.pop_front());
          @(negedge clk) dec_done_w = 1'b1;
          @(negedge clk) dec_done_w = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst && imem_en_w) begin
        if (exp_addr_w_q.size() == 0) check("w_extra_fetch", 32'(exp_addr_w_q.size()), 32'd1);
        else check("w_fetch_addr", 32'(imem_addr_w), 32'(exp_addr_w_q.pop_front()));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    exp_q.delete();
    exp_addr  = '0;
    fetch_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_halted(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("halted", 32'(halted), 32'd1);
  endtask

  task automatic push_prog(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back(imem[i]);
  endtask

  initial begin
    bit found;
    bit en_last;
    int n;
    rst = 1'b0; start = 1'b0; start_w = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h1000_0000 + i;
    for (int i = 0; i < 8; i++) imem_w[i] = 32'h2000_0000 + i;

    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    check("rst_rdy",    32'(rdy_bsy),    32'd0);
    check("rst_count",  32'(fifo_count), 32'd0);
    check("rst_pc",     32'(pc_out),     32'd0);
    check("rst_halted", 32'(halted),     32'd0);
    check("rst_en",     32'(imem_en),    32'd0);
    check("rst_instr",  instruction,     32'd0);
    check("rst_pc_w",   32'(pc_out_w),   32'd6);
    @(negedge clk) rst = 1'b1;

    // Basic stream
    imem[0] = 32'h00208033; imem[1] = 32'h40208033; imem[2] = 32'h0020F033; imem[3] = HALT;
    push_prog(0, 2);
    dec_auto = 1'b1; dec_delay = 2;
    pulse_start();
    wait_halted(300);
    check("basic_left",    32'(exp_q.size()), 32'd0);
    check("basic_pc",      32'(pc_out),       32'd4);
    check("basic_fetches", 32'(fetch_cnt),    32'd4);
    spur = 1'b1;
    pulse_start();
    repeat (6) @(posedge clk); #1;
    check("stop_halted",  32'(halted),     32'd1);
    check("stop_fetches", 32'(fetch_cnt),  32'd4);
    check("stop_pc",      32'(pc_out),     32'd4);

    // Backpressure
    do_reset();
    for (int i = 0; i < 4; i++) imem[i] = 32'h1000_0000 + i;
    imem[10] = HALT;
    push_prog(0, 9);
    dec_auto = 1'b0;
    pulse_start();
    repeat (20) @(posedge clk); #1;
    check("bp_fetches", 32'(fetch_cnt),  32'd5);
    check("bp_count",   32'(fifo_count), 32'd4);
    check("bp_en",      32'(imem_en),    32'd0);
    check("bp_pc",      32'(pc_out),     32'd5);
    dec_auto = 1'b1; dec_delay = 1;
    wait_halted(400);
    check("bp_left",    32'(exp_q.size()), 32'd0);
    check("bp_pc_end",  32'(pc_out),       32'd11);
    check("bp_fetch_end", 32'(fetch_cnt),  32'd11);

    // Simultaneous push/pop with a fast decoder
    do_reset();
    imem[10] = 32'h1000_000A; imem[12] = HALT;
    push_prog(0, 11);
    dec_delay = 0; pp_seen = 0;
    pulse_start();
    wait_halted(400);
    check("pp_left", 32'(exp_q.size()), 32'd0);
    check("pushpop_seen", 32'(pp_seen > 0), 32'd1);

    // Reset while waiting on the decoder with a read in flight
    do_reset();
    imem[12] = 32'h1000_000C;
    push_prog(0, 11);
    dec_auto = 1'b0;
    pulse_start();
    found = 1'b0; en_last = 1'b0; n = 0;
    while (!found && n < 50) begin
      @(posedge clk); #1;
      if (fifo_count == 3'd3 && en_last) found = 1'b1;
      en_last = imem_en;
      n++;
    end
    check("mid_found", 32'(found), 32'd1);
    @(negedge clk) rst = 1'b0;
    exp_q.delete(); exp_addr = '0; fetch_cnt = 0;
    @(posedge clk); #1;
    check("mid_rdy",    32'(rdy_bsy),    32'd0);
    check("mid_count",  32'(fifo_count), 32'd0);
    check("mid_pc",     32'(pc_out),     32'd0);
    check("mid_halted", 32'(halted),     32'd0);
    check("mid_instr",  instruction,     32'd0);
    @(negedge clk) rst = 1'b1;

    // Spurious dec_done while idle
    spur = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("spur_count",  32'(fifo_count), 32'd0);
    check("spur_pc",     32'(pc_out),     32'd0);
    check("spur_halted", 32'(halted),     32'd0);
    check("spur_en",     32'(imem_en),    32'd0);
    check("spur_rdy",    32'(rdy_bsy),    32'd0);

    // Restart after reset fetches from RESET_PC
    imem[4] = HALT;
    push_prog(0, 3);
    dec_auto = 1'b1; dec_delay = 1;
    pulse_start();
    wait_halted(300);
    check("rs_left",  32'(exp_q.size()), 32'd0);
    check("rs_pc",    32'(pc_out),       32'd5);
    check("rs_fetch", 32'(fetch_cnt),    32'd5);

    // PC wrap-around on the 3-bit instance
    imem_w[6] = 32'hA000_0006; imem_w[7] = 32'hA000_0007; imem_w[0] = 32'hA000_0000; imem_w[1] = HALT;
    exp_w_q.push_back(imem_w[6]); exp_w_q.push_back(imem_w[7]); exp_w_q.push_back(imem_w[0]);
    exp_addr_w_q.push_back(3'd6); exp_addr_w_q.push_back(3'd7);
    exp_addr_w_q.push_back(3'd0); exp_addr_w_q.push_back(3'd1);
    check("wrap_pc0", 32'(pc_out_w), 32'd6);
    @(negedge clk) start_w = 1'b1;
    @(negedge clk) start_w = 1'b0;
    n = 0;
    while (!halted_w && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("wrap_halted",    32'(halted_w),            32'd1);
    check("wrap_left",      32'(exp_w_q.size()),      32'd0);
    check("wrap_addr_left", 32'(exp_addr_w_q.size()), 32'd0);
    check("wrap_pc_end",    32'(pc_out_w),            32'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
